// File: rtl/piso_pkg.sv
// Shared definitions for the serial link transmit/receive blocks.
// State encoding, default word width and counter-width helper.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int PISO_WIDTH = 8;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int PISO_CNT_W = cnt_w(PISO_WIDTH);

endpackage

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter, LSB first, with one-word holding buffer.
// Ports: clk, rst_n, Valid_i/In_Data/Ready_o in, Out_Data/Valid_o/Last_o out.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Valid_i,
  input  logic [WIDTH-1:0] In_Data,
  output logic             Ready_o,
  output logic             Out_Data,
  output logic             Valid_o,
  output logic             Last_o
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_sh, w_sh;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic [WIDTH-1:0] r_hold, w_hold;
  logic             r_hold_full, w_hold_full;
  logic             r_out, w_out;
  logic             r_vld, w_vld;
  logic             r_last, w_last;

  logic             w_eow;
  logic             w_load;
  logic             w_direct;
  logic [WIDTH-1:0] w_src;
  logic [CW-1:0]    w_cnt_inc;

  assign w_eow     = (r_state == IDLE) || (r_cnt == LAST_CNT);
  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_state     = r_state;
    w_sh        = r_sh;
    w_cnt       = r_cnt;
    w_hold      = r_hold;
    w_hold_full = r_hold_full;
    w_out       = r_out;
    w_vld       = r_vld;
    w_last      = r_last;
    w_load      = 1'b0;
    w_direct    = 1'b0;
    w_src       = r_hold;

    if (w_eow) begin
      unique case (1'b1)
        r_hold_full: begin
          w_load      = 1'b1;
          w_src       = r_hold;
          w_hold_full = 1'b0;
        end
        (!r_hold_full && Valid_i): begin
          w_load   = 1'b1;
          w_direct = 1'b1;
          w_src    = In_Data;
        end
        default: begin
          w_state = IDLE;
          w_vld   = 1'b0;
          w_last  = 1'b0;
          w_out   = 1'b0;
        end
      endcase
    end else begin
      w_out  = r_sh[0];
      w_sh   = r_sh >> 1;
      w_cnt  = w_cnt_inc;
      w_last = (w_cnt_inc == LAST_CNT);
    end

    if (w_load) begin
      w_out   = w_src[0];
      w_sh    = w_src >> 1;
      w_cnt   = '0;
      w_vld   = 1'b1;
      w_last  = 1'b0;
      w_state = SHIFT;
    end

    // accept only when hold is empty; a direct load bypasses hold
    if (Valid_i && !r_hold_full && !w_direct) begin
      w_hold      = In_Data;
      w_hold_full = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sh        <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_out       <= 1'b0;
      r_vld       <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_sh        <= w_sh;
      r_cnt       <= w_cnt;
      r_hold      <= w_hold;
      r_hold_full <= w_hold_full;
      r_out       <= w_out;
      r_vld       <= w_vld;
      r_last      <= w_last;
    end
  end

  assign Ready_o  = !r_hold_full;
  assign Out_Data = r_out;
  assign Valid_o  = r_vld;
  assign Last_o   = r_last;

endmodule
